// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory stage: EX opcode encodings, the stage
// FSM state type, flag bit positions and an address-alignment helper.
package mem_stage_pkg;

    typedef enum logic [1:0] {
        OP_NONE = 2'b00,
        OP_LW   = 2'b01,
        OP_SW   = 2'b10,
        OP_RSVD = 2'b11
    } ex_op_e;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_e;

    localparam int FLAG_Z = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_N = 0;

    // Memory is halfword addressed; bit 0 of the ALU result is dropped.
    function automatic logic [15:0] word_addr(input logic [15:0] a);
        return {a[15:1], 1'b0};
    endfunction

endpackage

// File: rtl/mem_stage_flag_reg.sv
// flag_reg: 3-bit {Z,V,N} register with per-bit load enable.
// Ports: clk, rst_n (async, active-low), flag_in (new values),
//        load (per-bit enable), flag_q (registered flags).
module flag_reg (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] flag_in,
    input  logic [2:0] load,
    output logic [2:0] flag_q
);

    logic [2:0] flag_d;

    always_comb begin
        flag_d = flag_q;
        for (int i = 0; i < 3; i++) begin
            if (load[i]) flag_d[i] = flag_in[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) flag_q <= 3'b000;
        else        flag_q <= flag_d;
    end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: pipeline memory stage. Accepts one instruction from EX, issues a
// registered load/store request for LW/SW and waits for mem_ack (with a
// timeout), or forwards the ALU result straight to writeback otherwise.
// Ports: clk, rst_n | ex_* instruction from EX, stall back-pressure |
//        mem_* request/response | wb_* writeback pulse | flags, mem_err.
//
// state     | meaning
// ----------+---------------------------------------------------------
// ST_IDLE   | ready; accepts ex_valid, non-memory ops complete here
// ST_ACCESS | memory request outstanding, waiting for mem_ack/timeout
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid,
    input  logic [1:0]  ex_op,
    input  logic [15:0] ex_alu_res,
    input  logic [15:0] ex_wdata,
    input  logic [3:0]  ex_rd,
    input  logic        ex_we,
    input  logic [2:0]  ex_flag,
    input  logic [2:0]  ex_flag_en,
    output logic        stall,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ack,
    output logic        wb_valid,
    output logic        wb_we,
    output logic [3:0]  wb_rd,
    output logic [15:0] wb_data,
    output logic [2:0]  flags,
    output logic        mem_err
);

    localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d, cnt_inc;
    logic        mem_req_q, mem_req_d;
    logic        mem_wr_q, mem_wr_d;
    logic [15:0] mem_addr_q, mem_addr_d;
    logic [15:0] mem_wdata_q, mem_wdata_d;
    logic        wb_valid_q, wb_valid_d;
    logic        wb_we_q, wb_we_d;
    logic [3:0]  wb_rd_q, wb_rd_d;
    logic [15:0] wb_data_q, wb_data_d;
    logic        mem_err_q, mem_err_d;
    // Destination info of the outstanding memory op, replayed at completion.
    logic        acc_lw_q, acc_lw_d;
    logic        acc_we_q, acc_we_d;
    logic [3:0]  acc_rd_q, acc_rd_d;

    logic        accept;
    logic [2:0]  flag_load;

    assign accept  = (state_q == ST_IDLE) && ex_valid;
    assign cnt_inc = cnt_q + 4'd1;

    always_comb begin
        flag_load         = 3'b000;
        flag_load[FLAG_Z] = accept && ex_flag_en[FLAG_Z];
        flag_load[FLAG_V] = accept && ex_flag_en[FLAG_V];
        flag_load[FLAG_N] = accept && ex_flag_en[FLAG_N];
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mem_req_d   = mem_req_q;
        mem_wr_d    = mem_wr_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        wb_valid_d  = 1'b0;
        wb_we_d     = wb_we_q;
        wb_rd_d     = wb_rd_q;
        wb_data_d   = wb_data_q;
        mem_err_d   = 1'b0;
        acc_lw_d    = acc_lw_q;
        acc_we_d    = acc_we_q;
        acc_rd_d    = acc_rd_q;

        case (state_q)
            ST_IDLE: begin
                if (ex_valid) begin
                    if (ex_op == OP_LW || ex_op == OP_SW) begin
                        state_d     = ST_ACCESS;
                        cnt_d       = 4'd0;
                        mem_req_d   = 1'b1;
                        mem_wr_d    = (ex_op == OP_SW);
                        mem_addr_d  = word_addr(ex_alu_res);
                        mem_wdata_d = (ex_op == OP_SW) ? ex_wdata : 16'h0000;
                        acc_lw_d    = (ex_op == OP_LW);
                        acc_we_d    = ex_we;
                        acc_rd_d    = ex_rd;
                    end else begin
                        wb_valid_d = 1'b1;
                        wb_data_d  = ex_alu_res;
                        wb_rd_d    = ex_rd;
                        wb_we_d    = ex_we && (ex_op != OP_RSVD);
                    end
                end
            end
            ST_ACCESS: begin
                // A late ack on the timeout edge still counts as completion.
                if (mem_ack) begin
                    state_d    = ST_IDLE;
                    mem_req_d  = 1'b0;
                    wb_valid_d = 1'b1;
                    wb_rd_d    = acc_rd_q;
                    if (acc_lw_q) begin
                        wb_data_d = mem_rdata;
                        wb_we_d   = acc_we_q;
                    end else begin
                        wb_we_d   = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == MAX_WAIT_C) begin
                        state_d    = ST_IDLE;
                        mem_req_d  = 1'b0;
                        mem_err_d  = 1'b1;
                        wb_valid_d = 1'b1;
                        wb_we_d    = 1'b0;
                        wb_rd_d    = acc_rd_q;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            mem_req_q   <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_addr_q  <= 16'h0000;
            mem_wdata_q <= 16'h0000;
            wb_valid_q  <= 1'b0;
            wb_we_q     <= 1'b0;
            wb_rd_q     <= 4'd0;
            wb_data_q   <= 16'h0000;
            mem_err_q   <= 1'b0;
            acc_lw_q    <= 1'b0;
            acc_we_q    <= 1'b0;
            acc_rd_q    <= 4'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mem_req_q   <= mem_req_d;
            mem_wr_q    <= mem_wr_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            wb_valid_q  <= wb_valid_d;
            wb_we_q     <= wb_we_d;
            wb_rd_q     <= wb_rd_d;
            wb_data_q   <= wb_data_d;
            mem_err_q   <= mem_err_d;
            acc_lw_q    <= acc_lw_d;
            acc_we_q    <= acc_we_d;
            acc_rd_q    <= acc_rd_d;
        end
    end

    flag_reg u_flag_reg (
        .clk     (clk),
        .rst_n   (rst_n),
        .flag_in (ex_flag),
        .load    (flag_load),
        .flag_q  (flags)
    );

    assign stall     = (state_q == ST_ACCESS);
    assign mem_req   = mem_req_q;
    assign mem_wr    = mem_wr_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign wb_valid  = wb_valid_q;
    assign wb_we     = wb_we_q;
    assign wb_rd     = wb_rd_q;
    assign wb_data   = wb_data_q;
    assign mem_err   = mem_err_q;

endmodule
